// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, fetch FSM state encoding and width defaults
// shared by the fetch path of the 4-bit processor.
package cpu_pkg;

    localparam int DEF_ADDR_W         = 4;
    localparam int DEF_INSTR_W        = 8;
    localparam int DEF_TIMEOUT_CYCLES = 8;

    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_HALT    = 2'd3
    } fetch_state_t;

    // Opcodes the sequencer resolves itself and never hands downstream.
    function automatic logic is_ctrl_op(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JZ) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/branch_resolver.sv
// branch_resolver: decodes a latched opcode and the zero flag into
// halt / branch / load decisions and the load target.
module branch_resolver
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] operand,
    input  logic              cond_flag,
    output logic              is_halt,
    output logic              is_branch,
    output logic              take_load,
    output logic [ADDR_W-1:0] target
);

    // Control opcode decode; a non-taken JZ is a branch that increments.
    always_comb begin
        is_halt   = 1'b0;
        is_branch = 1'b0;
        take_load = 1'b0;
        target    = operand;
        unique case (1'b1)
            (opcode == OP_HLT): is_halt = 1'b1;
            (opcode == OP_JMP): begin
                is_branch = 1'b1;
                take_load = 1'b1;
            end
            (opcode == OP_JZ): begin
                is_branch = 1'b1;
                take_load = cond_flag;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/issue FSM driving the program counter.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int INSTR_W        = DEF_INSTR_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_out,
    output logic               pc_enable,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_in,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    input  logic               instr_ready,
    input  logic               cond_flag,
    output logic               halt,
    output logic               fetch_err
);

    fetch_state_t       state, state_nx;
    logic [INSTR_W-1:0] ir, ir_nx;
    logic [INSTR_W-1:0] instr_nx;
    logic [ADDR_W-1:0]  addr_nx, pcin_nx;
    logic               req_nx, en_nx, ld_nx;
    logic               valid_nx, halt_nx;

    logic [3:0]         opcode;
    logic [3:0]         ack_op;
    logic               br_halt, br_branch, br_load;
    logic [ADDR_W-1:0]  br_target;

    assign opcode = ir[INSTR_W-1 -: 4];
    assign ack_op = imem_data[INSTR_W-1 -: 4];

    branch_resolver #(
        .ADDR_W(ADDR_W)
    ) u_branch_resolver (
        .opcode   (opcode),
        .operand  (ir[ADDR_W-1:0]),
        .cond_flag(cond_flag),
        .is_halt  (br_halt),
        .is_branch(br_branch),
        .take_load(br_load),
        .target   (br_target)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
    logic             err, err_nx;

    assign fetch_err = err;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign fetch_err      = 1'b0;
`endif

    // Next state and next registered outputs; everything idles at 0.
    always_comb begin
        state_nx = state;
        ir_nx    = ir;
        req_nx   = 1'b0;
        addr_nx  = '0;
        en_nx    = 1'b0;
        ld_nx    = 1'b0;
        pcin_nx  = '0;
        valid_nx = 1'b0;
        instr_nx = '0;
        halt_nx  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_nx = wait_cnt;
        err_nx      = err;
`endif
        unique case (state)
            ST_FETCH: begin
                if (imem_req && imem_ack) begin
                    ir_nx    = imem_data;
                    state_nx = ST_ISSUE;
                    // Only plain instructions are ever offered downstream.
                    if (!is_ctrl_op(ack_op)) begin
                        valid_nx = 1'b1;
                        instr_nx = imem_data;
                    end
                end else begin
                    // First FETCH cycle after reset has no request yet.
                    req_nx  = 1'b1;
                    addr_nx = imem_req ? imem_addr : pc_out;
`ifdef FETCH_TIMEOUT_EN
                    if (imem_req) begin
                        if (wait_cnt == CNT_LAST) begin
                            req_nx   = 1'b0;
                            addr_nx  = '0;
                            err_nx   = 1'b1;
                            halt_nx  = 1'b1;
                            state_nx = ST_HALT;
                        end else begin
                            wait_cnt_nx = wait_cnt + CNT_W'(1);
                        end
                    end
`endif
                end
            end
            ST_ISSUE: begin
                if (br_halt) begin
                    halt_nx  = 1'b1;
                    state_nx = ST_HALT;
                end else if (br_branch) begin
                    ld_nx    = br_load;
                    en_nx    = !br_load;
                    pcin_nx  = br_load ? br_target : '0;
                    state_nx = ST_ADVANCE;
                end else if (instr_valid && instr_ready) begin
                    en_nx    = 1'b1;
                    state_nx = ST_ADVANCE;
                end else begin
                    valid_nx = instr_valid;
                    instr_nx = instr;
                end
            end
            ST_ADVANCE: begin
                // The request leaves together with the PC update, so
                // the address is the PC value the counter is moving to.
                req_nx   = 1'b1;
                addr_nx  = pc_load ? pc_in : pc_out + ADDR_W'(1);
                state_nx = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
                wait_cnt_nx = '0;
`endif
            end
            ST_HALT: begin
                halt_nx = 1'b1;
            end
            default: begin
                state_nx = ST_FETCH;
            end
        endcase
    end

    // State and output registers; reset aborts any fetch or issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_FETCH;
            ir          <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            pc_enable   <= 1'b0;
            pc_load     <= 1'b0;
            pc_in       <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            halt        <= 1'b0;
        end else begin
            state       <= state_nx;
            ir          <= ir_nx;
            imem_req    <= req_nx;
            imem_addr   <= addr_nx;
            pc_enable   <= en_nx;
            pc_load     <= ld_nx;
            pc_in       <= pcin_nx;
            instr_valid <= valid_nx;
            instr       <= instr_nx;
            halt        <= halt_nx;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Fetch watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nx;
            err      <= err_nx;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios for fetch_sequencer with a
// bench-side program counter and instruction ROM.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] pc_out;
    logic       pc_enable;
    logic       pc_load;
    logic [3:0] pc_in;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       cond_flag;
    logic       halt;
    logic       fetch_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [16];
    int         ack_wait;
    bit         spurious;
    int         rq_cnt;
    int         cyc;
    int         n_en, n_ld, n_both, n_ctrl_valid, n_req, n_unstable;
    logic [3:0] ld_tgt;
    logic [3:0] addr_q [$];
    logic [7:0] instr_q [$];
    int         hs_t [$];
    logic       prev_req, prev_ack;
    logic [3:0] prev_addr;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .pc_out     (pc_out),
        .pc_enable  (pc_enable),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .cond_flag  (cond_flag),
        .halt       (halt),
        .fetch_err  (fetch_err)
    );

    task automatic clear_logs();
        n_en = 0; n_ld = 0; n_both = 0; n_ctrl_valid = 0;
        n_req = 0; n_unstable = 0; ld_tgt = 4'h0; cyc = 0;
        addr_q.delete(); instr_q.delete(); hs_t.delete();
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 4'h0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pc_out = 4'h0; imem_ack = 1'b0; imem_data = 8'h00;
        instr_ready = 1'b1; cond_flag = 1'b0;
        ack_wait = 0; spurious = 1'b0; rq_cnt = 0;
        for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
        clear_logs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock: memory response and logging at the falling edge,
    // then the counter update just after the rising edge.
    task automatic tick();
        logic       en, ld;
        logic [3:0] tgt;
        if (imem_req) begin
            rq_cnt++;
            imem_ack = (rq_cnt > ack_wait);
            imem_data = imem_ack ? rom[imem_addr] : 8'h00;
            n_req++;
        end else begin
            rq_cnt = 0;
            imem_ack = spurious;
            imem_data = spurious ? 8'hF0 : 8'h00;
        end
        if (prev_req && !prev_ack && imem_req && imem_addr !== prev_addr)
            n_unstable++;
        prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
        if (imem_req && imem_ack) addr_q.push_back(imem_addr);
        if (instr_valid && instr_ready) begin
            instr_q.push_back(instr);
            hs_t.push_back(cyc);
        end
        if (instr_valid && (instr[7:4] == 4'hA || instr[7:4] == 4'hB ||
                            instr[7:4] == 4'hF))
            n_ctrl_valid++;
        if (pc_enable) n_en++;
        if (pc_load) begin
            n_ld++;
            ld_tgt = pc_in;
        end
        if (pc_enable && pc_load) n_both++;
        en = pc_enable; ld = pc_load; tgt = pc_in;
        @(posedge clk);
        #1;
        if (ld) pc_out = tgt;
        else if (en) pc_out = pc_out + 4'h1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pc_out = 4'h0; imem_ack = 1'b0; imem_data = 8'h00;
        instr_ready = 1'b1; cond_flag = 1'b0;
        ack_wait = 0; spurious = 1'b0; rq_cnt = 0;
        for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
        clear_logs();
        repeat (3) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rst_req got %b want 0", imem_req);
        end
        checks++;
        if (imem_addr !== 4'h0) begin
            errors++; $display("FAIL rst_addr got %h want 0", imem_addr);
        end
        checks++;
        if ({pc_enable, pc_load, pc_in} !== 6'h00) begin
            errors++;
            $display("FAIL rst_pc got %b%b%h want 000",
                     pc_enable, pc_load, pc_in);
        end
        checks++;
        if ({instr_valid, instr} !== 9'h000) begin
            errors++;
            $display("FAIL rst_instr got %b/%h want 0/00",
                     instr_valid, instr);
        end
        checks++;
        if ({halt, fetch_err} !== 2'b00) begin
            errors++;
            $display("FAIL rst_halt got %b%b want 00", halt, fetch_err);
        end
        reset = 1'b1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rel_req0 got %b want 0", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 4'h0) begin
            errors++;
            $display("FAIL rel_req1 got %b@%h want 1@0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56;
        ack_wait = 1;
        for (int i = 0; i < 80 && halt !== 1'b1; i++) tick();
        checks++;
        if (instr_q.size() !== 3 || instr_q[0] !== 8'h12 ||
            instr_q[1] !== 8'h34 || instr_q[2] !== 8'h56) begin
            errors++;
            $display("FAIL seq_instr got n=%0d %h %h %h want 3 12 34 56",
                     instr_q.size(), instr_q[0], instr_q[1], instr_q[2]);
        end
        checks++;
        if (addr_q.size() !== 4 || addr_q[0] !== 4'h0 ||
            addr_q[1] !== 4'h1 || addr_q[2] !== 4'h2 ||
            addr_q[3] !== 4'h3) begin
            errors++;
            $display("FAIL seq_addr got n=%0d %h %h %h want 4 0 1 2",
                     addr_q.size(), addr_q[0], addr_q[1], addr_q[2]);
        end
        checks++;
        if (n_en !== 3 || n_ld !== 0) begin
            errors++;
            $display("FAIL seq_pc got en=%0d ld=%0d want en=3 ld=0",
                     n_en, n_ld);
        end
        checks++;
        if (n_unstable !== 0) begin
            errors++;
            $display("FAIL seq_addr_hold got %0d changes want 0",
                     n_unstable);
        end
        checks++;
        if (halt !== 1'b1) begin
            errors++; $display("FAIL seq_halt got %b want 1", halt);
        end
    endtask

    task automatic test_jmp();
        do_reset();
        rom[0] = 8'h12; rom[1] = 8'hA9; rom[9] = 8'h5C;
        for (int i = 0; i < 80 && halt !== 1'b1; i++) tick();
        checks++;
        if (n_ld !== 1 || ld_tgt !== 4'h9) begin
            errors++;
            $display("FAIL jmp_load got n=%0d tgt=%h want n=1 tgt=9",
                     n_ld, ld_tgt);
        end
        checks++;
        if (addr_q.size() !== 4 || addr_q[1] !== 4'h1 ||
            addr_q[2] !== 4'h9 || addr_q[3] !== 4'hA) begin
            errors++;
            $display("FAIL jmp_addr got n=%0d %h %h %h want 4 1 9 a",
                     addr_q.size(), addr_q[1], addr_q[2], addr_q[3]);
        end
        checks++;
        if (instr_q.size() !== 2 || instr_q[0] !== 8'h12 ||
            instr_q[1] !== 8'h5C) begin
            errors++;
            $display("FAIL jmp_instr got n=%0d %h %h want 2 12 5c",
                     instr_q.size(), instr_q[0], instr_q[1]);
        end
        checks++;
        if (n_ctrl_valid !== 0 || n_both !== 0 || n_en !== 2) begin
            errors++;
            $display("FAIL jmp_misc got ctrl=%0d both=%0d en=%0d want 0 0 2",
                     n_ctrl_valid, n_both, n_en);
        end
    endtask

    task automatic test_jz();
        for (int run = 0; run < 2; run++) begin
            do_reset();
            rom[0] = 8'h01; rom[1] = 8'h02; rom[2] = 8'h03;
            rom[3] = 8'hB7;
            cond_flag = (run == 0);
            for (int i = 0; i < 80 && halt !== 1'b1; i++) tick();
            checks++;
            if (run == 0 && (n_ld !== 1 || ld_tgt !== 4'h7 ||
                             n_en !== 3)) begin
                errors++;
                $display("FAIL jz_taken got ld=%0d tgt=%h en=%0d want 1 7 3",
                         n_ld, ld_tgt, n_en);
            end else if (run == 1 && (n_ld !== 0 || n_en !== 4)) begin
                errors++;
                $display("FAIL jz_not_taken got ld=%0d en=%0d want 0 4",
                         n_ld, n_en);
            end
            checks++;
            if (addr_q.size() !== 5 ||
                addr_q[4] !== (run == 0 ? 4'h7 : 4'h4)) begin
                errors++;
                $display("FAIL jz_next_addr run%0d got n=%0d %h want 5 %h",
                         run, addr_q.size(), addr_q[4],
                         (run == 0 ? 4'h7 : 4'h4));
            end
            checks++;
            if (instr_q.size() !== 3 || n_ctrl_valid !== 0) begin
                errors++;
                $display("FAIL jz_issue run%0d got n=%0d ctrl=%0d want 3 0",
                         run, instr_q.size(), n_ctrl_valid);
            end
        end
    endtask

    task automatic test_backpressure_wrap();
        int en0, ld0, bad;
        do_reset();
        rom[0] = 8'hAF; rom[15] = 8'h77;
        instr_ready = 1'b0;
        for (int i = 0; i < 40 && instr_valid !== 1'b1; i++) tick();
        checks++;
        if (instr_valid !== 1'b1 || pc_out !== 4'hF) begin
            errors++;
            $display("FAIL bp_present got v=%b pc=%h want 1 f",
                     instr_valid, pc_out);
        end
        en0 = n_en; ld0 = n_ld; bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (instr_valid !== 1'b1 || instr !== 8'h77) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad);
        end
        checks++;
        if (n_en !== en0 || n_ld !== ld0 || ld0 !== 1) begin
            errors++;
            $display("FAIL bp_no_pc got en=%0d ld=%0d want %0d 1",
                     n_en, n_ld, en0);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 40 && addr_q.size() < 3; i++) tick();
        checks++;
        if (addr_q.size() !== 3 || addr_q[1] !== 4'hF ||
            addr_q[2] !== 4'h0) begin
            errors++;
            $display("FAIL wrap_addr got n=%0d %h %h want 3 f 0",
                     addr_q.size(), addr_q[1], addr_q[2]);
        end
        checks++;
        if (n_en !== en0 + 1 || instr_q.size() !== 1 ||
            instr_q[0] !== 8'h77) begin
            errors++;
            $display("FAIL wrap_issue got en=%0d n=%0d i=%h want %0d 1 77",
                     n_en, instr_q.size(), instr_q[0], en0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33;
        spurious = 1'b1;
        for (int i = 0; i < 60 && halt !== 1'b1; i++) tick();
        checks++;
        if (instr_q.size() !== 3 || instr_q[2] !== 8'h33) begin
            errors++;
            $display("FAIL b2b_instr got n=%0d last=%h want 3 33",
                     instr_q.size(), instr_q[2]);
        end
        checks++;
        if (hs_t.size() !== 3 || hs_t[1] - hs_t[0] !== 3 ||
            hs_t[2] - hs_t[0] !== 6) begin
            errors++;
            $display("FAIL b2b_rate got n=%0d d1=%0d d2=%0d want 3 3 6",
                     hs_t.size(), hs_t[1] - hs_t[0], hs_t[2] - hs_t[0]);
        end
        checks++;
        if (addr_q.size() !== 4 || addr_q[3] !== 4'h3 || halt !== 1'b1) begin
            errors++;
            $display("FAIL b2b_spur_ack got n=%0d last=%h h=%b want 4 3 1",
                     addr_q.size(), addr_q[3], halt);
        end
    endtask

    task automatic test_halt();
        int req0;
        do_reset();
        rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'hF0;
        for (int i = 0; i < 60 && halt !== 1'b1; i++) tick();
        checks++;
        if (halt !== 1'b1 || addr_q.size() !== 3 || n_en !== 2) begin
            errors++;
            $display("FAIL halt_reach got h=%b n=%0d en=%0d want 1 3 2",
                     halt, addr_q.size(), n_en);
        end
        req0 = n_req;
        repeat (6) tick();
        checks++;
        if (n_req !== req0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_no_req got %0d req cycles want 0",
                     n_req - req0);
        end
        checks++;
        if ({pc_enable, pc_load, instr_valid, halt} !== 4'b0001 ||
            n_ctrl_valid !== 0) begin
            errors++;
            $display("FAIL halt_outs got %b%b%b%b ctrl=%0d want 0001 0",
                     pc_enable, pc_load, instr_valid, halt, n_ctrl_valid);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        rom[0] = 8'h12;
        ack_wait = 5;
        repeat (3) tick();
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL abort_pre_req got %b want 1", imem_req);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL abort_fetch got %b want 0", imem_req);
        end
        do_reset();
        rom[0] = 8'h12;
        instr_ready = 1'b0;
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 8'h00) begin
            errors++;
            $display("FAIL abort_issue got %b/%h want 0/00",
                     instr_valid, instr);
        end
        do_reset();
        for (int i = 0; i < 20 && halt !== 1'b1; i++) tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (halt !== 1'b0) begin
            errors++; $display("FAIL abort_halt got %b want 0", halt);
        end
        do_reset();
        rom[0] = 8'h12;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 4'h0) begin
            errors++;
            $display("FAIL refetch got %b@%h want 1@0", imem_req, imem_addr);
        end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        ack_wait = 1000;
        for (int i = 0; i < 40 && halt !== 1'b1; i++) tick();
        checks++;
        if (halt !== 1'b1 || fetch_err !== 1'b1 || n_req !== 8) begin
            errors++;
            $display("FAIL tmo_fire got h=%b e=%b req=%0d want 1 1 8",
                     halt, fetch_err, n_req);
        end
        repeat (3) tick();
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL tmo_sticky got e=%b req=%b want 1 0",
                     fetch_err, imem_req);
        end
        do_reset();
        rom[0] = 8'h12;
        ack_wait = 7;
        for (int i = 0; i < 80 && halt !== 1'b1; i++) tick();
        checks++;
        if (fetch_err !== 1'b0 || instr_q.size() !== 1 ||
            instr_q[0] !== 8'h12 || addr_q.size() !== 2) begin
            errors++;
            $display("FAIL tmo_last_ack got e=%b n=%0d i=%h a=%0d want 0 1 12 2",
                     fetch_err, instr_q.size(), instr_q[0], addr_q.size());
        end
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        rom[0] = 8'h12;
        ack_wait = 20;
        repeat (15) tick();
        checks++;
        if (halt !== 1'b0 || imem_req !== 1'b1 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL wait_forever got h=%b req=%b e=%b want 0 1 0",
                     halt, imem_req, fetch_err);
        end
        for (int i = 0; i < 80 && halt !== 1'b1; i++) tick();
        checks++;
        if (instr_q.size() !== 1 || instr_q[0] !== 8'h12 ||
            fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL late_ack got n=%0d i=%h e=%b want 1 12 0",
                     instr_q.size(), instr_q[0], fetch_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_jmp();
        test_jz();
        test_backpressure_wrap();
        test_back_to_back();
        test_halt();
        test_reset_abort();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control-side partner of the program counter in the 4-bit processor. Consumes pc_out and produces pc_enable, pc_load and pc_in.
- Fetches 8-bit instructions from instruction memory over a req/ack handshake and resolves JMP, JZ and HLT internally.
- Hands all other instructions to the execute stage over a valid/ready handshake.
- Sits between ProgramCounter, instruction ROM and the decode/execute path.

Parameters:
- ADDR_W, 4, PC/instruction-address width.
- INSTR_W, 8, instruction width; opcode = [7:4], operand = [3:0].
- TIMEOUT_CYCLES, 8, maximum imem_ack wait. Used only when FETCH_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- pc_out  in  ADDR_W  current PC from program counter
- pc_enable  out  1  one-cycle increment request to PC
- pc_load  out  1  one-cycle load request to PC
- pc_in  out  ADDR_W  load target, meaningful when pc_load=1
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address
- imem_ack  in  1  memory returns imem_data this cycle
- imem_data  in  INSTR_W  fetched instruction
- instr_valid  out  1  instruction presented downstream
- instr  out  INSTR_W  instruction to execute stage
- instr_ready  in  1  downstream accepts
- cond_flag  in  1  zero flag from ALU, used by JZ
- halt  out  1  processor halted
- fetch_err  out  1  fetch timeout; tied 0 without macro

Behaviour:
- Reset: while reset=0, all outputs are 0 and state = FETCH. imem_req rises on the first clock edge after reset deasserts.
- All outputs are registered.
- States:
  - FETCH: imem_req=1, imem_addr=pc_out, both held stable until imem_ack. On ack, latch imem_data, drop imem_req, go to ISSUE. Ack on the first req cycle is legal.
  - ISSUE: decode the latched opcode.
    - HLT (4'hF): go to HALT.
    - JMP (4'hA): go to ADVANCE with load, pc_in=operand.
    - JZ (4'hB), cond_flag=1: go to ADVANCE with load, pc_in=operand.
    - JZ (4'hB), cond_flag=0: go to ADVANCE with increment.
    - Any other opcode: instr_valid=1, instr=latched value, held until instr_ready=1; on handshake, drop instr_valid and go to ADVANCE with increment.
    - cond_flag is sampled in the first ISSUE cycle.
  - ADVANCE: exactly one cycle with pc_enable=1 or pc_load=1, never both. Next state FETCH.
  - HALT: halt=1. All other outputs 0. Stays in HALT until reset.
- Jumps and HLT are never presented on instr_valid.
- Latency: ack edge to ISSUE is 1 cycle. A non-branch instruction with ready already high costs 3 cycles per instruction: FETCH(ack), ISSUE, ADVANCE.
- FETCH in the cycle after ADVANCE sees the updated pc_out.
- Wrap-around: PC 15 increments to 0 (handled by the counter). The next fetch is address 0 with no special case.
- Asynchronous reset mid-FETCH or mid-ISSUE aborts immediately: imem_req and instr_valid drop asynchronously and any latched instruction is discarded.
- imem_ack outside FETCH is ignored.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A wait counter clears on FETCH entry and increments each FETCH cycle without ack.
  - After TIMEOUT_CYCLES cycles without ack: imem_req drops, fetch_err=1 (sticky until reset), state goes to HALT with halt=1.
  - An ack on the final allowed cycle is accepted normally.
- Undefined: no counter; fetch waits indefinitely; fetch_err is constant 0.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_JMP=4'hA, OP_JZ=4'hB, OP_HLT=4'hF
  - state encoding typedef (FETCH, ISSUE, ADVANCE, HALT)
  - ADDR_W and INSTR_W defaults
- One natural sub-module, branch_resolver: combinational opcode + cond_flag to {is_halt, is_branch, take_load, target}.
- FSM and timeout counter stay in fetch_sequencer.

Test Plan:
- Sequential fetch: ROM[0..2]=8'h12,8'h34,8'h56, ack one cycle after req, ready=1 → instr 12,34,56 in order; one pc_enable pulse after each; imem_addr 0,1,2; no pc_load.
- JMP: ROM[1]=8'hA9 → pc_load=1 with pc_in=9 for exactly one cycle; instr_valid never high for A9; next imem_addr=9.
- JZ: ROM[3]=8'hB7 twice, once with cond_flag=1 and once with cond_flag=0 → first run pc_load with pc_in=7; second run pc_enable, next address 4.
- Backpressure and wrap: instr_ready low 5 cycles at PC=15 → instr_valid and instr held stable, no PC pulse; after ready, pc_enable, and next imem_addr=0.
- Halt and reset: ROM[2]=8'hF0 → halt=1 and no further imem_req. Separately, drive reset=0 while imem_req=1 → imem_req=0 asynchronously and halt cleared; refetch starts after release.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack withheld → fetch_err=1 and halt=1 after 8 cycles. A second run with ack on cycle 8 proceeds normally.
